// File: rtl/seq_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_pkg
// Brief    : Shared types and default constants for the programmable serial
//            sequence detector (seq_detect_prog, seq_hist_shift).
// Revision : 1.0 - initial release
// ============================================================================
package seq_detect_pkg;

  // Default maximum pattern length in bits.
  localparam int c_max_len_default = 8;

  // Default width of the optional match counter.
  localparam int c_cnt_w_default = 16;

  // Detector control states.
  typedef enum logic [1:0] {
    UNCFG  = 2'd0,
    FILL   = 2'd1,
    DETECT = 2'd2
  } state_t;

endpackage : seq_detect_pkg
`default_nettype wire

// File: rtl/seq_hist_shift.sv
`default_nettype none
// ============================================================================
// Module   : seq_hist_shift
// Brief    : Serial history shift register with saturating fill counter and
//            length-masked pattern compare. The match and full flags describe
//            the history as it will be once the bit on in_bit is accepted.
// Revision : 1.0 - initial release
// ============================================================================
module seq_hist_shift
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = c_max_len_default,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,        // synchronous, active-low
  input  logic               clr_all,    // clear history and fill count
  input  logic               clr_fill,   // restart fill count with this shift
  input  logic               shift_en,   // accept in_bit this cycle
  input  logic               in_bit,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               match,      // masked compare including in_bit
  output logic               full        // fill count reaches len with in_bit
);

  // Only the newest MAX_LEN-1 past bits need storing: together with the
  // incoming bit they form the full MAX_LEN-wide compare window.
  logic [MAX_LEN-2:0] r_hist;
  logic [LEN_W-1:0]   r_fill;

  logic [MAX_LEN-1:0] w_hist_next;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W-1:0]   w_fill_inc;

  assign w_hist_next = {r_hist, in_bit};
  assign w_fill_inc  = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + 1'b1;

  // Mask selects the lowest len bits; bits above len are don't-care.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
    assign w_mask[gi] = (LEN_W'(gi) < len);
  end

  assign match = (((w_hist_next ^ pattern) & w_mask) == '0);
  assign full  = (w_fill_inc >= len);

  // History and fill count; a clear on configuration beats any shift.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (clr_all) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (shift_en) begin
      r_hist <= w_hist_next[MAX_LEN-2:0];
      r_fill <= clr_fill ? '0 : w_fill_inc;
    end
  end

endmodule : seq_hist_shift
`default_nettype wire

// File: rtl/seq_detect_prog.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_prog
// Brief    : Programmable serial sequence detector. Pattern, length and
//            overlap mode are loaded at run time; a registered one-cycle
//            pulse on out reports each match.
//            Optional feature macro: SEQ_MATCH_CNT_EN adds a saturating
//            match counter on port match_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = c_max_len_default,
  parameter int CNT_W   = c_cnt_w_default
) (
  input  logic                               clk,
  input  logic                               rst,          // sync, active-low
  input  logic                               in_valid,
  input  logic                               in,
  input  logic                               cfg_load,
  input  logic [MAX_LEN-1:0]                 cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]       cfg_len,
  input  logic                               cfg_overlap,
  output logic                               out,
  output logic                               cfg_err
`ifdef SEQ_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0]                   match_cnt
`endif
);

  localparam int c_len_w = $clog2(MAX_LEN + 1);

  // Reject unsupported parameterisations at elaboration.
  if (MAX_LEN < 2 || MAX_LEN > 32 || CNT_W < 1) begin : g_param_check
    $error("seq_detect_prog: MAX_LEN must be 2..32 and CNT_W >= 1");
  end

  state_t               r_state;
  state_t               w_state_nxt;

  logic [MAX_LEN-1:0]   r_pat;
  logic [c_len_w-1:0]   r_len;
  logic                 r_ovl;
  logic                 r_out;
  logic                 r_err;

  logic                 w_cfg_ok;
  logic                 w_accept;
  logic                 w_match;
  logic                 w_full;
  logic                 w_hit;
  logic                 w_err_nxt;

  // A load is accepted only for a length the history window can hold.
  assign w_cfg_ok = cfg_load && (cfg_len >= c_len_w'(2)) &&
                    (cfg_len <= c_len_w'(MAX_LEN));

  // Data bits are consumed only once configured, and lose to a cfg_load.
  assign w_accept = in_valid && !cfg_load && (r_state != UNCFG);

  seq_hist_shift #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (c_len_w)
  ) u_hist (
    .clk      (clk),
    .rst      (rst),
    .clr_all  (w_cfg_ok),
    .clr_fill (w_hit && !r_ovl),
    .shift_en (w_accept),
    .in_bit   (in),
    .pattern  (r_pat),
    .len      (r_len),
    .match    (w_match),
    .full     (w_full)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= UNCFG;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: a good load restarts filling; a non-overlap hit refills.
  always_comb begin
    w_state_nxt = r_state;
    if (w_cfg_ok) begin
      w_state_nxt = FILL;
    end else if (w_accept) begin
      if (w_hit && !r_ovl) begin
        w_state_nxt = FILL;
      end else if (r_state == FILL && w_full) begin
        w_state_nxt = DETECT;
      end
    end
  end

  // Output decode: a hit needs a full window, including the completing bit.
  always_comb begin
    w_hit     = w_accept && w_match &&
                ((r_state == DETECT) || (r_state == FILL && w_full));
    w_err_nxt = cfg_load && !w_cfg_ok;
  end

  // Latched configuration, cleared by reset and replaced on a good load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pat <= '0;
      r_len <= '0;
      r_ovl <= 1'b0;
    end else if (w_cfg_ok) begin
      r_pat <= cfg_pattern;
      r_len <= cfg_len;
      r_ovl <= cfg_overlap;
    end
  end

  // Registered one-cycle pulses for match and rejected load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_out <= w_hit;
      r_err <= w_err_nxt;
    end
  end

  assign out     = r_out;
  assign cfg_err = r_err;

`ifdef SEQ_MATCH_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Saturating match counter, restarted by a good load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_cfg_ok) begin
      r_cnt <= '0;
    end else if (w_hit && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign match_cnt = r_cnt;
`else
`endif

endmodule : seq_detect_prog
`default_nettype wire

// File: tb/tb_seq_detect_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detect_prog
// Brief    : Self-checking bench for seq_detect_prog: queue-based reference
//            model compared every cycle, directed scenarios with literal
//            expectations, then randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detect_prog;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 3;
  localparam int LW      = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_bit = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LW-1:0]      cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               out;
  logic               cfg_err;
`ifdef SEQ_MATCH_CNT_EN
  logic [CNT_W-1:0]   match_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int pulses = 0;
  int errs = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  seq_detect_prog #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in          (in_bit),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .out         (out),
    .cfg_err     (cfg_err)
`ifdef SEQ_MATCH_CNT_EN
    ,
    .match_cnt   (match_cnt)
`endif
  );

  // ---------------- reference model ----------------
  // Bits received since the last (re)start, oldest first.
  bit                 q[$];
  bit                 m_cfgd;
  logic [MAX_LEN-1:0] m_pat;
  int                 m_len;
  bit                 m_ovl;
  bit                 e_out;
  bit                 e_err;
  int                 e_cnt;

  always @(posedge clk) begin
    bit hit;
    e_out = 1'b0;
    e_err = 1'b0;
    if (!rst) begin
      m_cfgd = 1'b0;
      q.delete();
      e_cnt = 0;
    end else if (cfg_load) begin
      if (int'(cfg_len) >= 2 && int'(cfg_len) <= MAX_LEN) begin
        m_cfgd = 1'b1;
        m_pat  = cfg_pattern;
        m_len  = int'(cfg_len);
        m_ovl  = cfg_overlap;
        q.delete();
        e_cnt  = 0;
      end else begin
        e_err = 1'b1;
      end
    end else if (in_valid && m_cfgd) begin
      q.push_back(in_bit);
      if (q.size() > MAX_LEN) void'(q.pop_front());
      hit = (q.size() >= m_len);
      for (int k = 0; k < MAX_LEN; k++)
        if (hit && k < m_len && q[q.size()-1-k] != m_pat[k]) hit = 1'b0;
      if (hit) begin
        e_out = 1'b1;
        if (e_cnt < (1 << CNT_W) - 1) e_cnt++;
        if (!m_ovl) q.delete();
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if (out !== e_out) begin
        fails++;
        $display("FAIL out t=%0t got %b want %b", $time, out, e_out);
      end
      tests++;
      if (cfg_err !== e_err) begin
        fails++;
        $display("FAIL cfg_err t=%0t got %b want %b", $time, cfg_err, e_err);
      end
`ifdef SEQ_MATCH_CNT_EN
      tests++;
      if (int'(match_cnt) != e_cnt) begin
        fails++;
        $display("FAIL match_cnt t=%0t got %0d want %0d", $time, match_cnt, e_cnt);
      end
`endif
      if (out === 1'b1) pulses++;
      if (cfg_err === 1'b1) errs++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drv(input logic v, input logic b, input logic ld,
                     input logic [MAX_LEN-1:0] pat, input logic [LW-1:0] len,
                     input logic ovl);
    in_valid = v; in_bit = b; cfg_load = ld;
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_load = 1'b0;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 1'b0, cfg_pattern, cfg_len, cfg_overlap);
  endtask

  task automatic load(input logic [MAX_LEN-1:0] pat, input logic [LW-1:0] len,
                      input logic ovl);
    drv(1'b0, 1'b0, 1'b1, pat, len, ovl);
  endtask

  // Send a string of '0'/'1', first character is the oldest bit.
  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++)
      drv(1'b1, (s[i] == "1"), 1'b0, cfg_pattern, cfg_len, cfg_overlap);
  endtask

  // Let the pulse of the last edge reach the compare process.
  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic expect_eq(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int p0;
    int e0;
    int r;

    // Reset for 2 cycles with distracting inputs present.
    rst = 1'b0;
    in_valid = 1'b1; in_bit = 1'b1; cfg_load = 1'b1; cfg_len = 4'd4;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_load = 1'b0;
    settle();
    expect_eq("reset_out", int'(out), 0);
    expect_eq("reset_err", int'(cfg_err), 0);
`ifdef SEQ_MATCH_CNT_EN
    expect_eq("reset_cnt", int'(match_cnt), 0);
`endif
    rst = 1'b1;

    // Unconfigured: bits are ignored.
    p0 = pulses;
    send("1011"); idle(); settle();
    expect_eq("uncfg_pulses", pulses - p0, 0);

    // Overlapping detection of 1011 in 1011011.
    load(8'b0000_1011, 4'd4, 1'b1);
    p0 = pulses;
    send("1011"); settle();
    expect_eq("ovl_first_pulse", int'(out), 1);
    send("011"); settle();
    expect_eq("ovl_pulses", pulses - p0, 2);
`ifdef SEQ_MATCH_CNT_EN
    expect_eq("ovl_cnt", int'(match_cnt), 2);
`endif

    // Non-overlapping detection.
    load(8'b0000_1011, 4'd4, 1'b0);
    p0 = pulses;
    send("1011011"); idle(); settle();
    expect_eq("novl_pulses", pulses - p0, 1);
`ifdef SEQ_MATCH_CNT_EN
    expect_eq("novl_cnt", int'(match_cnt), 1);
`endif

    // Rejected loads: length 0 and MAX_LEN+1; old config keeps working.
    e0 = errs;
    load(8'hFF, 4'd0, 1'b1);
    load(8'hFF, 4'(MAX_LEN + 1), 1'b1);
    idle(); settle();
    expect_eq("bad_cfg_errs", errs - e0, 2);
    p0 = pulses;
    send("1011"); idle(); settle();
    expect_eq("old_cfg_pulses", pulses - p0, 1);

    // Reset mid-sequence discards partial history.
    load(8'b0000_1011, 4'd4, 1'b1);
    send("101");
    rst = 1'b0; idle(); rst = 1'b1;
    load(8'b0000_1011, 4'd4, 1'b1);
    p0 = pulses;
    send("1"); idle(); settle();
    expect_eq("post_reset_none", pulses - p0, 0);
    send("011"); idle(); settle();
    expect_eq("post_reset_pulse", pulses - p0, 1);

    // Gaps are ignored; a load colliding with a valid bit drops that bit.
    load(8'b0000_1011, 4'd4, 1'b1);
    p0 = pulses;
    send("1"); idle(); send("0"); idle(); idle(); send("1"); idle(); send("1");
    settle();
    expect_eq("gap_pulse", pulses - p0, 1);
    drv(1'b1, 1'b1, 1'b1, 8'b0000_1011, 4'd4, 1'b1);
    p0 = pulses;
    send("011"); idle(); settle();
    expect_eq("collide_dropped", pulses - p0, 0);
    send("1011"); idle(); settle();
    expect_eq("collide_refill", pulses - p0, 1);

    // Counter saturation: pattern 11, len 2, ten ones give nine matches.
    load(8'b0000_0011, 4'd2, 1'b1);
    p0 = pulses;
    send("1111111111"); idle(); settle();
    expect_eq("sat_pulses", pulses - p0, 9);
`ifdef SEQ_MATCH_CNT_EN
    expect_eq("sat_cnt", int'(match_cnt), (1 << CNT_W) - 1);
`endif

    // Randomized traffic checked by the model every cycle.
    for (int n = 0; n < 4000; n++) begin
      r = int'($urandom_range(0, 999));
      rst = (r >= 4);
      if (r >= 4 && r < 34) begin
        if (r % 3 == 0)
          load(MAX_LEN'($urandom()), LW'($urandom_range(0, MAX_LEN + 1)), 1'($urandom()));
        else
          load(MAX_LEN'($urandom()), LW'($urandom_range(2, 4)), 1'($urandom()));
      end else begin
        drv(($urandom_range(0, 9) < 7), 1'($urandom()), ($urandom_range(0, 199) == 0),
            cfg_pattern, cfg_len, cfg_overlap);
      end
    end
    rst = 1'b1;
    idle(); settle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_seq_detect_prog
`default_nettype wire
